fetch_unit: RTL and testbench

Fetch stage of the SEQ Y86-64 processor: holds the architectural PC register, reads instruction bytes from a 64-bit-wide instruction memory through a req/ack handshake, and splits them into icode/ifun/rA/rB/valC/valP for decode. It is the stage directly downstream of PC update. The PC register loads `new_PC` from PC update, and the fetched fields feed decode, execute and PC update. Status (AOK/HLT/ADR/INS) is generated here and is sticky once non-AOK.

---
 rtl/fetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_unit.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// SEQ Y86-64 fetch stage: PC register, 1- or 2-word instruction memory read,
// field split and status generation, handing fields to decode over valid/ready.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [63:0] new_PC,
  input  logic        pc_load,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [63:0] imem_rdata,
  input  logic        imem_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [63:0] PC,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic [2:0]  stat,
  output logic        halted
);

  typedef enum logic [2:0] {IDLE, REQ0, REQ1, VALID, WAIT, HALT} state_t;
  localparam logic [2:0] S_AOK = 3'd1, S_HLT = 3'd2, S_ADR = 3'd3, S_INS = 3'd4;

  state_t      state;
  logic [63:0] word0;
  logic [63:0] lo, hi;
  logic [79:0] b;
  logic [3:0]  d_icode, d_ifun, d_len, fmax;
  logic [63:0] d_valc;
  logic        regs, bad, done;
  logic [2:0]  d_stat;
  logic [4:0]  span;

  // Decode straight off the arriving word so fields register on the ack edge.
  always_comb begin
    lo      = (state == REQ1) ? word0 : imem_rdata;
    hi      = (state == REQ1) ? imem_rdata : 64'h0;
    b       = 80'({hi, lo} >> {PC[2:0], 3'b000});
    d_icode = b[7:4];
    d_ifun  = b[3:0];
    d_len   = 4'd1;
    fmax    = 4'd0;
    regs    = 1'b0;
    bad     = 1'b0;
    d_valc  = 64'h0;
    case (d_icode)
      4'h0, 4'h1, 4'h9: ;
      4'h2:             begin d_len = 4'd2;  regs = 1'b1; fmax = 4'd6; end
      4'h3, 4'h4, 4'h5: begin d_len = 4'd10; regs = 1'b1; d_valc = b[79:16]; end
      4'h6:             begin d_len = 4'd2;  regs = 1'b1; fmax = 4'd3; end
      4'h7:             begin d_len = 4'd9;  fmax = 4'd6; d_valc = b[71:8]; end
      4'h8:             begin d_len = 4'd9;  d_valc = b[71:8]; end
      4'hA, 4'hB:       begin d_len = 4'd2;  regs = 1'b1; end
      default:          bad = 1'b1;
    endcase
    d_stat = (bad || d_ifun > fmax) ? S_INS : (d_icode == 4'h0) ? S_HLT : S_AOK;
    span   = {2'b00, PC[2:0]} + {1'b0, d_len};
    done   = imem_ack && ((state == REQ0 && (imem_err || span <= 5'd8)) || state == REQ1);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= IDLE;
      PC         <= RESET_PC;
      word0      <= 64'h0;
      imem_req   <= 1'b0;
      imem_addr  <= 64'h0;
      inst_valid <= 1'b0;
      icode      <= 4'h0;
      ifun       <= 4'h0;
      rA         <= 4'h0;
      rB         <= 4'h0;
      valC       <= 64'h0;
      valP       <= 64'h0;
      stat       <= S_AOK;
      halted     <= 1'b0;
    end else begin
      if (done) begin
        icode      <= d_icode;
        ifun       <= d_ifun;
        rA         <= regs ? b[15:12] : 4'hF;
        rB         <= regs ? b[11:8]  : 4'hF;
        valC       <= d_valc;
        valP       <= PC + {60'h0, d_len};
        stat       <= imem_err ? S_ADR : d_stat;
        imem_req   <= 1'b0;
        inst_valid <= 1'b1;
        state      <= VALID;
      end
      case (state)
        IDLE: begin
          state     <= REQ0;
          imem_req  <= 1'b1;
          imem_addr <= {PC[63:3], 3'b000};
        end
        REQ0: if (imem_ack) begin
          word0 <= imem_rdata;
          if (!done) begin
            state     <= REQ1;
            imem_addr <= imem_addr + 64'd8;
          end
        end
        REQ1: ;
        VALID: if (inst_ready) begin
          inst_valid <= 1'b0;
          if (stat != S_AOK) begin
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: if (pc_load) begin
          PC        <= new_PC;
          imem_req  <= 1'b1;
          imem_addr <= {new_PC[63:3], 3'b000};
          state     <= REQ0;
        end
        HALT: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: byte-addressed memory responder with random
// ack latency, and a byte-level reference model of the Y86-64 fetch rules.
module tb_fetch_unit;

  localparam logic [63:0] RST_PC = 64'h100;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic [63:0] new_PC = 64'h0;
  logic        pc_load = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [63:0] imem_rdata = 64'h0;
  logic        imem_err = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [63:0] PC;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP;
  logic [2:0]  stat;
  logic        halted;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .new_PC(new_PC), .pc_load(pc_load),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .imem_err(imem_err), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .PC(PC), .icode(icode), .ifun(ifun), .rA(rA),
    .rB(rB), .valC(valC), .valP(valP), .stat(stat), .halted(halted)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
    logic [2:0]  stat;
    int          nw;
  } exp_t;

  logic [7:0]  mem [logic [63:0]];
  bit          err_word [logic [63:0]];
  logic [63:0] addr_q [$];
  int          ack_pct = 100;
  logic [63:0] hold_addr = 64'h1;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, expv);
    end
  endtask

  function automatic logic [7:0] rd(input logic [63:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  // Memory responder: random latency, garbage ack/err while no request.
  always @(negedge Clk) begin
    if (!Rst_n) begin
      imem_ack = 1'b0;
    end else if (imem_req && imem_addr != hold_addr && $urandom_range(99) < ack_pct) begin
      imem_ack = 1'b1;
      for (int k = 0; k < 8; k++) imem_rdata[8*k +: 8] = rd(imem_addr + 64'(k));
      imem_err = err_word.exists(imem_addr);
      addr_q.push_back(imem_addr);
    end else begin
      imem_ack   = !imem_req && ($urandom_range(1) == 1);
      imem_rdata = {$urandom, $urandom};
      imem_err   = ($urandom_range(1) == 1);
    end
  end

  function automatic int ilen(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       return 1;
      4'h2, 4'h6, 4'hA, 4'hB: return 2;
      4'h7, 4'h8:             return 9;
      4'h3, 4'h4, 4'h5:       return 10;
      default:                return 0;
    endcase
  endfunction

  function automatic int ifmax(input logic [3:0] ic);
    return (ic == 4'h2 || ic == 4'h7) ? 6 : (ic == 4'h6) ? 3 : 0;
  endfunction

  function automatic exp_t model(input logic [63:0] pc);
    exp_t        e;
    logic [7:0]  b [10];
    logic [63:0] base;
    int          off, len;
    bit          ins, regs, err;
    off  = int'(pc[2:0]);
    base = {pc[63:3], 3'b000};
    for (int k = 0; k < 10; k++) b[k] = (off + k < 16) ? rd(pc + 64'(k)) : 8'h00;
    e.icode = b[0][7:4];
    e.ifun  = b[0][3:0];
    len     = ilen(e.icode);
    ins     = (len == 0) || (int'(e.ifun) > ifmax(e.icode));
    if (len == 0) len = 1;
    regs = (e.icode >= 4'h2 && e.icode <= 4'h6) || e.icode == 4'hA || e.icode == 4'hB;
    e.ra = regs ? b[1][7:4] : 4'hF;
    e.rb = regs ? b[1][3:0] : 4'hF;
    e.valc = 64'h0;
    if (e.icode >= 4'h3 && e.icode <= 4'h5)
      for (int k = 0; k < 8; k++) e.valc[8*k +: 8] = b[2+k];
    else if (e.icode == 4'h7 || e.icode == 4'h8)
      for (int k = 0; k < 8; k++) e.valc[8*k +: 8] = b[1+k];
    e.valp = pc + 64'(len);
    e.nw   = err_word.exists(base) ? 1 : (off + len > 8) ? 2 : 1;
    err    = err_word.exists(base) || (e.nw == 2 && err_word.exists(base + 64'd8));
    e.stat = err ? 3'd3 : ins ? 3'd4 : (e.icode == 4'h0) ? 3'd2 : 3'd1;
    return e;
  endfunction

  task automatic wait_valid();
    int n = 0;
    while (!inst_valid && n < 300) begin
      @(negedge Clk);
      n++;
    end
    chk("valid_timeout", inst_valid, 1'b1);
  endtask

  // Compare against the model, hold for a few cycles with stray pc_load, then accept.
  task automatic check_accept(input logic [63:0] pc);
    exp_t        e;
    logic [63:0] base;
    e    = model(pc);
    base = {pc[63:3], 3'b000};
    chk("stat", stat, e.stat);
    if (e.stat != 3'd3) begin
      chk("icode", icode, e.icode);
      chk("ifun", ifun, e.ifun);
      chk("rA", rA, e.ra);
      chk("rB", rB, e.rb);
      chk("valC", valC, e.valc);
      chk("valP", valP, e.valp);
    end
    chk("PC", PC, pc);
    chk("nreads", addr_q.size(), e.nw);
    for (int i = 0; i < e.nw && i < addr_q.size(); i++)
      chk("raddr", addr_q[i], base + 64'(8 * i));
    addr_q.delete();
    repeat ($urandom_range(3)) begin
      pc_load = 1'b1;
      new_PC  = {$urandom, $urandom};
      @(negedge Clk);
      chk("hold_PC", PC, pc);
      chk("hold_vld", inst_valid, 1'b1);
    end
    pc_load    = 1'b0;
    inst_ready = 1'b1;
    @(negedge Clk);
    inst_ready = 1'b0;
    chk("vld_drop", inst_valid, 1'b0);
    chk("halted", halted, e.stat != 3'd1);
  endtask

  task automatic load_pc(input logic [63:0] npc);
    repeat ($urandom_range(2)) @(negedge Clk);
    pc_load = 1'b1;
    new_PC  = npc;
    @(negedge Clk);
    pc_load = 1'b0;
    chk("load_PC", PC, npc);
    chk("load_req", imem_req, 1'b1);
    chk("load_addr", imem_addr, {npc[63:3], 3'b000});
  endtask

  task automatic fetch(input logic [63:0] pc);
    load_pc(pc);
    wait_valid();
    check_accept(pc);
  endtask

  task automatic put(input logic [63:0] a, input logic [7:0] bytes [], input int n);
    for (int k = 0; k < n; k++) mem[a + 64'(k)] = bytes[k];
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_vld", inst_valid, 1'b0);
    chk("rst_PC", PC, RST_PC);
    chk("rst_stat", stat, 3'd1);
    chk("rst_halted", halted, 1'b0);
    chk("rst_fields", {icode, ifun, rA, rB}, 16'h0);
    chk("rst_valC", valC, 64'h0);
    chk("rst_valP", valP, 64'h0);
    chk("rst_addr", imem_addr, 64'h0);
    repeat (2) @(negedge Clk);
    addr_q.delete();
    Rst_n = 1'b1;
    @(negedge Clk);
    chk("first_req", imem_req, 1'b1);
    chk("first_addr", imem_addr, RST_PC);
    wait_valid();
    check_accept(RST_PC);
  endtask

  task automatic halted_idle();
    for (int i = 0; i < 4; i++) begin
      pc_load = 1'b1;
      new_PC  = 64'h40;
      @(negedge Clk);
      chk("halt_noreq", imem_req, 1'b0);
    end
    pc_load = 1'b0;
    chk("halt_PC_kept", halted, 1'b1);
  endtask

  initial begin
    logic [7:0]  bs [];
    logic [63:0] pc;
    logic [3:0]  ic;
    int          n;
    mem[RST_PC] = 8'h10;

    do_reset();

    // straddling irmovq at 0
    bs = '{8'h30, 8'hF3, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    put(64'h0, bs, 10);
    load_pc(64'h0);
    wait_valid();
    chk("irm_fields", {icode, ifun, rA, rB}, 16'h30F3);
    chk("irm_valC", valC, 64'd10);
    chk("irm_valP", valP, 64'd10);
    check_accept(64'h0);

    // nop at offset 5
    mem[64'h5] = 8'h10;
    load_pc(64'h5);
    wait_valid();
    chk("nop_valP", valP, 64'h6);
    chk("nop_regs", {rA, rB}, 8'hFF);
    check_accept(64'h5);

    // jmp at 0x0E to 0x40
    bs = '{8'h70, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    put(64'h0E, bs, 9);
    load_pc(64'h0E);
    wait_valid();
    chk("jmp_valC", valC, 64'h40);
    chk("jmp_valP", valP, 64'h17);
    check_accept(64'h0E);
    mem[64'h40] = 8'h10;
    fetch(64'h40);

    // random legal instructions, random latency, some wrapping past 2^64
    for (int it = 0; it < 40; it++) begin
      ack_pct = 20 + $urandom_range(80);
      pc = ($urandom_range(4) == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(15))
                                    : 64'h1000 + 64'($urandom_range(4000));
      ic = 4'($urandom_range(1, 11));
      n  = ilen(ic);
      bs = new[n];
      bs[0] = {ic, 4'($urandom_range(ifmax(ic)))};
      for (int k = 1; k < n; k++) bs[k] = 8'($urandom_range(255));
      put(pc, bs, n);
      fetch(pc);
    end
    ack_pct = 100;

    // address error on second word of a 10-byte instruction
    bs = '{8'h30, 8'hF1, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    put(64'h206, bs, 10);
    err_word[64'h208] = 1'b1;
    load_pc(64'h206);
    wait_valid();
    chk("adr_stat", stat, 3'd3);
    check_accept(64'h206);
    halted_idle();

    // invalid icode
    do_reset();
    mem[64'h300] = 8'hC0;
    load_pc(64'h300);
    wait_valid();
    chk("ins_stat", stat, 3'd4);
    chk("ins_valP", valP, 64'h301);
    check_accept(64'h300);
    halted_idle();

    // halt
    do_reset();
    mem[64'h400] = 8'h00;
    load_pc(64'h400);
    wait_valid();
    chk("hlt_stat", stat, 3'd2);
    check_accept(64'h400);
    halted_idle();

    // reset in the middle of the second word read
    do_reset();
    put(64'h506, bs, 10);
    hold_addr = 64'h508;
    load_pc(64'h506);
    n = 0;
    while (!(imem_req && imem_addr == 64'h508) && n < 100) begin
      @(negedge Clk);
      n++;
    end
    chk("req1_seen", imem_addr, 64'h508);
    #2 Rst_n = 1'b0;
    #1;
    chk("mid_rst_req", imem_req, 1'b0);
    chk("mid_rst_PC", PC, RST_PC);
    chk("mid_rst_vld", inst_valid, 1'b0);
    repeat (2) @(negedge Clk);
    addr_q.delete();
    hold_addr = 64'h1;
    Rst_n = 1'b1;
    wait_valid();
    chk("post_rst_addr", (addr_q.size() > 0) ? addr_q[0] : 64'hDEAD, RST_PC);
    check_accept(RST_PC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
